mips_data_mem_arbiter: RTL and testbench

//  Two-master arbiter sharing the single mips_cpu_data_memory port between the CPU data port (m0)
//  and a loader/debug master (m1) that preloads or inspects data memory around a program run.

---
 rtl/mips_mem_arb_pkg.sv | 26 ++
 rtl/mips_mem_arb_rr.sv | 19 +
 rtl/mips_data_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mips_data_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-return owner tags, priority FSM states
// and a saturating increment used by the optional MEM_ARB_PERF_EN counters.
package mips_mem_arb_pkg;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } rd_tag_t;

   typedef enum logic {
      ST_PRIO_M0 = 1'b0,
      ST_PRIO_M1 = 1'b1
   } prio_state_t;

   localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_M0};

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
      return (inc && (v != '1)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/mips_mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the priority holder.
module mips_mem_arb_rr
   import mips_mem_arb_pkg::*;
(
   input  logic [1:0]  req,
   input  prio_state_t prio,
   output logic [1:0]  gnt
);

   always_comb begin
      gnt = '0;
      if (req[0] && (!req[1] || (prio == ST_PRIO_M0))) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// Arbitrates the CPU data port (m0) and a loader/debug master (m1) onto one data-memory port,
// routing pipelined read data back by owner tag. MEM_ARB_PERF_EN adds grant/conflict counters.
module mips_data_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clk_enable,
   input  logic          m0_req,
   input  logic          m0_write,
   input  logic [AW-1:0] m0_address,
   input  logic [DW-1:0] m0_writedata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_readdata,
   input  logic          m1_req,
   input  logic          m1_write,
   input  logic [AW-1:0] m1_address,
   input  logic [DW-1:0] m1_writedata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_readdata,
   output logic [AW-1:0] mem_address,
   output logic          mem_write,
   output logic          mem_read,
   output logic [DW-1:0] mem_writedata,
   input  logic [DW-1:0] mem_readdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_gnt_m0,
   output logic [31:0]   perf_gnt_m1,
   output logic [31:0]   perf_conflict
`endif
);

   prio_state_t   prio_q, prio_d;
   rd_tag_t       tag_q [RD_LATENCY];
   rd_tag_t       tag_d [RD_LATENCY];
   rd_tag_t       tag_out;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic [1:0]    req, gnt;
   logic          granted, sel_wr;

   // Reset is folded into the request gate so grants and strobes drop asynchronously with it.
   assign req = {m1_req, m0_req} & {2{clk_enable & ~reset}};

   mips_mem_arb_rr u_rr (
      .req  (req),
      .prio (prio_q),
      .gnt  (gnt)
   );

   always_comb begin
      granted = |gnt;
      sel_wr  = gnt[1] ? m1_write : m0_write;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (granted) begin
         addr_d  = gnt[1] ? m1_address   : m0_address;
         wdata_d = gnt[1] ? m1_writedata : m0_writedata;
      end

      prio_d = prio_q;
      if (gnt[0]) begin
         prio_d = ST_PRIO_M1;
      end else if (gnt[1]) begin
         prio_d = ST_PRIO_M0;
      end

      tag_d = tag_q;
      if (clk_enable) begin
         tag_d[0] = '{valid: granted & ~sel_wr, owner: (gnt[1] ? OWN_M1 : OWN_M0)};
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
         end
      end

      // A frozen pipeline keeps its tag; the return fires on the first enabled cycle.
      tag_out   = tag_q[RD_LATENCY-1];
      m0_rvalid = clk_enable & tag_out.valid & (tag_out.owner == OWN_M0);
      m1_rvalid = clk_enable & tag_out.valid & (tag_out.owner == OWN_M1);
      rdata0_d  = m0_rvalid ? mem_readdata : rdata0_q;
      rdata1_d  = m1_rvalid ? mem_readdata : rdata1_q;
   end

   assign m0_gnt        = gnt[0];
   assign m1_gnt        = gnt[1];
   assign mem_write     = granted & sel_wr;
   assign mem_read      = granted & ~sel_wr;
   assign mem_address   = addr_d;
   assign mem_writedata = wdata_d;
   assign m0_readdata   = rdata0_d;
   assign m1_readdata   = rdata1_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q   <= ST_PRIO_M0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= TAG_IDLE;
         end
      end else begin
         prio_q   <= prio_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         tag_q    <= tag_d;
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [31:0] pgnt0_q, pgnt0_d;
   logic [31:0] pgnt1_q, pgnt1_d;
   logic [31:0] pconf_q, pconf_d;

   always_comb begin
      pgnt0_d = sat_inc(pgnt0_q, gnt[0]);
      pgnt1_d = sat_inc(pgnt1_q, gnt[1]);
      pconf_d = sat_inc(pconf_q, req[0] & req[1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pgnt0_q <= '0;
         pgnt1_q <= '0;
         pconf_q <= '0;
      end else begin
         pgnt0_q <= pgnt0_d;
         pgnt1_q <= pgnt1_d;
         pconf_q <= pconf_d;
      end
   end

   assign perf_gnt_m0   = pgnt0_q;
   assign perf_gnt_m1   = pgnt1_q;
   assign perf_conflict = pconf_q;
`endif

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Directed bench for mips_data_mem_arbiter: a latency-1 instance checked through a read-return
// scoreboard and a latency-3 instance for reset-during-read; MEM_ARB_PERF_EN checks counters.
`timescale 1ns/1ps
module tb_mips_data_mem_arbiter;
   import mips_mem_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        owner;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   // latency-1 instance
   logic        reset, clk_enable;
   logic        m0_req, m0_write, m0_gnt, m0_rvalid;
   logic [31:0] m0_address, m0_writedata, m0_readdata;
   logic        m1_req, m1_write, m1_gnt, m1_rvalid;
   logic [31:0] m1_address, m1_writedata, m1_readdata;
   logic [31:0] mem_address, mem_writedata, mem_readdata;
   logic        mem_write, mem_read;
   // latency-3 instance
   logic        c_rst, c_en;
   logic        c_m0_req, c_m0_write, c_m0_gnt, c_m0_rvalid;
   logic [31:0] c_m0_address, c_m0_writedata, c_m0_readdata;
   logic        c_m1_req, c_m1_write, c_m1_gnt, c_m1_rvalid;
   logic [31:0] c_m1_address, c_m1_writedata, c_m1_readdata;
   logic [31:0] c_mem_address, c_mem_writedata, c_mem_readdata;
   logic        c_mem_write, c_mem_read;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_gnt_m0, perf_gnt_m1, perf_conflict;
   logic [31:0] c_perf_gnt_m0, c_perf_gnt_m1, c_perf_conflict;
`endif

   mips_data_mem_arbiter #(.RD_LATENCY(1), .AW(32), .DW(32)) u_dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable),
      .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address),
      .m0_writedata(m0_writedata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_readdata(m0_readdata),
      .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address),
      .m1_writedata(m1_writedata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_readdata(m1_readdata),
      .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
`ifdef MEM_ARB_PERF_EN
      , .perf_gnt_m0(perf_gnt_m0), .perf_gnt_m1(perf_gnt_m1), .perf_conflict(perf_conflict)
`endif
   );

   mips_data_mem_arbiter #(.RD_LATENCY(3), .AW(32), .DW(32)) u_dut3 (
      .clk(clk), .reset(c_rst), .clk_enable(c_en),
      .m0_req(c_m0_req), .m0_write(c_m0_write), .m0_address(c_m0_address),
      .m0_writedata(c_m0_writedata), .m0_gnt(c_m0_gnt), .m0_rvalid(c_m0_rvalid),
      .m0_readdata(c_m0_readdata),
      .m1_req(c_m1_req), .m1_write(c_m1_write), .m1_address(c_m1_address),
      .m1_writedata(c_m1_writedata), .m1_gnt(c_m1_gnt), .m1_rvalid(c_m1_rvalid),
      .m1_readdata(c_m1_readdata),
      .mem_address(c_mem_address), .mem_write(c_mem_write), .mem_read(c_mem_read),
      .mem_writedata(c_mem_writedata), .mem_readdata(c_mem_readdata)
`ifdef MEM_ARB_PERF_EN
      , .perf_gnt_m0(c_perf_gnt_m0), .perf_gnt_m1(c_perf_gnt_m1), .perf_conflict(c_perf_conflict)
`endif
   );

   function automatic logic [31:0] init_val(input int idx);
      return (idx == 4) ? 32'hDEADBEEF : (32'hA500_0000 | idx);
   endfunction

   // Synchronous memories; the read path advances only with clk_enable, like the CPU memory.
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] pipe3 [3];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem1[i] <= init_val(i);
      end else if (clk_enable) begin
         if (mem_write) mem1[mem_address[7:2]] <= mem_writedata;
         mem_readdata <= mem_read ? mem1[mem_address[7:2]] : 32'hBAD0BAD0;
      end
   end
   always @(posedge clk) begin
      if (c_rst) begin
         for (int i = 0; i < 64; i++) mem3[i] <= init_val(i);
      end else if (c_en) begin
         if (c_mem_write) mem3[c_mem_address[7:2]] <= c_mem_writedata;
         pipe3[0] <= c_mem_read ? mem3[c_mem_address[7:2]] : 32'hBAD0BAD0;
         pipe3[1] <= pipe3[0];
         pipe3[2] <= pipe3[1];
      end
   end
   assign c_mem_readdata = pipe3[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
      m0_req = rq; m0_write = wr; m0_address = a; m0_writedata = d;
   endtask

   task automatic drv1(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
      m1_req = rq; m1_write = wr; m1_address = a; m1_writedata = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic owner, input logic [31:0] data, input int due);
      exp_t e;
      e.owner = owner; e.data = data; e.due = due;
      sb.push_back(e);
   endtask

   // Read-return monitor for the latency-1 instance.
   always @(negedge clk) begin
      if (m0_rvalid || m1_rvalid) begin
         checks++;
         assert ((sb.size() != 0) && !(m0_rvalid && m1_rvalid)) else begin
            errors++;
            $error("FAIL rvalid_unexpected: observed m0=%b m1=%b pending=%0d expected one pulse for an issued read",
                   m0_rvalid, m1_rvalid, sb.size());
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("rvalid_owner", {31'd0, m1_rvalid}, {31'd0, mon_e.owner});
            chk("rvalid_cycle", cyc, mon_e.due);
            chk("readdata", m1_rvalid ? m1_readdata : m0_readdata, mon_e.data);
         end
      end
   end

   logic [31:0] exp_data [5];
   logic [31:0] a0, a1;
   logic        win1;

   initial begin
      exp_data[0] = 32'hA500_0010; exp_data[1] = 32'hA500_0020; exp_data[2] = 32'hA500_0011;
      exp_data[3] = 32'hA500_0021; exp_data[4] = 32'hA500_0012;
      reset = 1'b1; clk_enable = 1'b1;
      drv0(1'b1, 1'b0, 32'h10, 32'h0);
      drv1(1'b0, 1'b0, 32'h0, 32'h0);
      c_rst = 1'b1; c_en = 1'b1;
      c_m0_req = 1'b0; c_m0_write = 1'b0; c_m0_address = '0; c_m0_writedata = '0;
      c_m1_req = 1'b0; c_m1_write = 1'b0; c_m1_address = '0; c_m1_writedata = '0;
      repeat (2) next_cycle();
      #1;
      chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_m0_readdata", m0_readdata, 32'd0);
      chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

      // single m0 read, returned the next cycle
      next_cycle();
      reset = 1'b0;
      #1;
      chk("t1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      chk("t1_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
      chk("t1_mem_address", mem_address, 32'h10);
      push(1'b0, 32'hDEADBEEF, cyc + 1);
      next_cycle();
      drv0(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("idle_addr_hold", mem_address, 32'h10);

      // both masters streaming reads from reset: strict alternation starting with m0
      next_cycle(); reset = 1'b1;
      next_cycle(); reset = 1'b0;
      a0 = 32'h40; a1 = 32'h80;
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         drv0(1'b1, 1'b0, a0, 32'h0);
         drv1(1'b1, 1'b0, a1, 32'h0);
         #1;
         win1 = (k % 2) == 1;
         chk("t2_m0_gnt", {31'd0, m0_gnt}, {31'd0, !win1});
         chk("t2_m1_gnt", {31'd0, m1_gnt}, {31'd0, win1});
         chk("t2_mem_address", mem_address, win1 ? a1 : a0);
         push(win1, exp_data[k], cyc + 1);
         if (win1) a1 = a1 + 32'd4;
         else      a0 = a0 + 32'd4;
      end
      next_cycle();
      drv0(1'b0, 1'b0, 32'h0, 32'h0);
      drv1(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
`ifdef MEM_ARB_PERF_EN
      chk("perf_conflict", perf_conflict, 32'd5);
      chk("perf_gnt_m0", perf_gnt_m0, 32'd3);
      chk("perf_gnt_m1", perf_gnt_m1, 32'd2);
      chk("perf_gnt_sum", perf_gnt_m0 + perf_gnt_m1, 32'd5);
`endif

      // write by m1 then read-after-write by m0
      next_cycle();
      drv1(1'b1, 1'b1, 32'h20, 32'h1);
      #1;
      chk("t3_m1_gnt", {31'd0, m1_gnt}, 32'd1);
      chk("t3_mem_write", {31'd0, mem_write}, 32'd1);
      chk("t3_mem_read", {31'd0, mem_read}, 32'd0);
      chk("t3_mem_writedata", mem_writedata, 32'h1);
      next_cycle();
      drv1(1'b0, 1'b0, 32'h0, 32'h0);
      drv0(1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      chk("t3_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      push(1'b0, 32'h1, cyc + 1);
      next_cycle();
      drv0(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("t3_idle_write", {31'd0, mem_write}, 32'd0);

      // freeze with a read in flight; priority was handed to m1 by the m0 read
      next_cycle();
      drv0(1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("t5_issue_gnt", {31'd0, m0_gnt}, 32'd1);
      push(1'b0, 32'hDEADBEEF, cyc + 4);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         clk_enable = 1'b0;
         drv0(1'b1, 1'b0, 32'h44, 32'h0);
         drv1(1'b1, 1'b0, 32'h80, 32'h0);
         #1;
         chk("t5_frozen_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
         chk("t5_frozen_strobes", {30'd0, mem_write, mem_read}, 32'd0);
      end
      next_cycle();
      clk_enable = 1'b1;
      #1;
      chk("t5_resume_m1_gnt", {31'd0, m1_gnt}, 32'd1);
      chk("t5_resume_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      push(1'b1, 32'hA500_0020, cyc + 1);
      next_cycle();
      drv1(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("t5_m0_gnt", {31'd0, m0_gnt}, 32'd1);
      push(1'b0, 32'hA500_0011, cyc + 1);
      next_cycle();
      drv0(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) next_cycle();
      chk("sb_drained", sb.size(), 32'd0);

      // latency-3 instance: normal read, then a read killed by reset
      next_cycle();
      c_rst = 1'b0;
      c_m0_req = 1'b1; c_m0_address = 32'h10;
      #1;
      chk("l3_gnt", {31'd0, c_m0_gnt}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         next_cycle();
         c_m0_req = 1'b0;
         #1;
         chk("l3_rvalid", {31'd0, c_m0_rvalid}, (k == 3) ? 32'd1 : 32'd0);
      end
      chk("l3_readdata", c_m0_readdata, 32'hDEADBEEF);
      next_cycle();
      c_m0_req = 1'b1; c_m0_address = 32'h44;
      #1;
      chk("t4_gnt", {31'd0, c_m0_gnt}, 32'd1);
      next_cycle();
      c_m0_req = 1'b0; c_rst = 1'b1;
      #1;
      chk("t4_rst_gnt", {30'd0, c_m1_gnt, c_m0_gnt}, 32'd0);
      chk("t4_rst_addr", c_mem_address, 32'd0);
      next_cycle();
      c_rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t4_rvalid", {30'd0, c_m1_rvalid, c_m0_rvalid}, 32'd0);
         chk("t4_readdata", c_m0_readdata | c_m1_readdata, 32'd0);
         chk("t4_mem_out", c_mem_address | c_mem_writedata, 32'd0);
         chk("t4_strobes", {30'd0, c_mem_write, c_mem_read}, 32'd0);
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
